// File: rtl/synapse_acc_pkg.sv
// Shared types and constants for the synapse accumulator array:
// FSM state encoding and signed saturation bounds derived from accumulator width.
package synapse_acc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } acc_state_e;

  function automatic int sat_max(input int unsigned acc_bits);
    return (1 << (acc_bits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned acc_bits);
    return -(1 << (acc_bits - 1));
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One saturating accumulator lane: sign-extends a weight, adds it to the
// current accumulator value and clamps to the signed accumulator range.
module sat_add_lane
  import synapse_acc_pkg::*;
#(
  parameter int unsigned W_BITS   = 4,
  parameter int unsigned ACC_BITS = 8
) (
  input  logic [ACC_BITS-1:0] acc,
  input  logic [W_BITS-1:0]   weight,
  output logic [ACC_BITS-1:0] sum_c,
  output logic                ovf_c
);

  localparam int unsigned SW = ACC_BITS + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(sat_max(ACC_BITS));
  localparam logic signed [SW-1:0] MIN_V = SW'(sat_min(ACC_BITS));

  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] w_x;
  logic signed [SW-1:0] sum;

  // One extra bit of headroom makes the unclamped sum exact
  assign acc_x = SW'($signed(acc));
  assign w_x   = SW'($signed(weight));
  assign sum   = acc_x + w_x;

  always_comb begin
    sum_c = sum[ACC_BITS-1:0];
    ovf_c = 1'b0;
    if (sum > MAX_V) begin
      sum_c = MAX_V[ACC_BITS-1:0];
      ovf_c = 1'b1;
    end else if (sum < MIN_V) begin
      sum_c = MIN_V[ACC_BITS-1:0];
      ovf_c = 1'b1;
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Array of N signed saturating neuron accumulators, charged one group of
// WPW lanes per handshake, with a group-per-cycle clear sweep and word reads.
module synapse_accumulator
  import synapse_acc_pkg::*;
#(
  parameter int unsigned N        = 256,
  parameter int unsigned W_BITS   = 4,
  parameter int unsigned ACC_BITS = 8,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                                       CLK,
  input  logic                                       RSTN,
  input  logic                                       chg_valid_i,
  output logic                                       chg_ready_o,
  input  logic [$clog2(N/(DATA_W/W_BITS))-1:0]       chg_group_i,
  input  logic [DATA_W-1:0]                          chg_data_i,
  input  logic                                       clr_req_i,
  output logic                                       busy_o,
  input  logic                                       rd_en_i,
  input  logic [$clog2(N/(DATA_W/ACC_BITS))-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]                          rd_data_o,
  output logic                                       rd_valid_o,
  output logic                                       sat_flag_o,
  input  logic                                       sat_clr_i
);

  localparam int unsigned WPW    = DATA_W / W_BITS;
  localparam int unsigned RPW    = DATA_W / ACC_BITS;
  localparam int unsigned GROUPS = N / WPW;
  localparam int unsigned RWORDS = N / RPW;
  localparam int unsigned G_W    = $clog2(GROUPS);
  localparam int unsigned R_W    = $clog2(RWORDS);

  acc_state_e          state;
  logic [G_W-1:0]      clr_idx;
  logic [ACC_BITS-1:0] acc      [N];
  logic [ACC_BITS-1:0] lane_acc [WPW];
  logic [ACC_BITS-1:0] lane_sum [WPW];
  logic [WPW-1:0]      lane_ovf;
  logic [DATA_W-1:0]   rd_word;
  logic                chg_fire;

  assign chg_ready_o = (state == ST_IDLE) && !clr_req_i;
  assign chg_fire    = chg_valid_i && chg_ready_o;
  assign busy_o      = (state == ST_CLEAR);

  // Clear sweep: one group per cycle, requests during the sweep are ignored
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req_i) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == G_W'(GROUPS - 1)) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + G_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Gather the current values of the targeted group into the lane adders
  always_comb begin
    for (int unsigned k = 0; k < WPW; k++) lane_acc[k] = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (chg_group_i == G_W'(g)) begin
        for (int unsigned k = 0; k < WPW; k++) lane_acc[k] = acc[g*WPW + k];
      end
    end
  end

  for (genvar k = 0; k < WPW; k++) begin : g_lane
    sat_add_lane #(
      .W_BITS  (W_BITS),
      .ACC_BITS(ACC_BITS)
    ) u_lane (
      .acc   (lane_acc[k]),
      .weight(chg_data_i[k*W_BITS +: W_BITS]),
      .sum_c (lane_sum[k]),
      .ovf_c (lane_ovf[k])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_acc
    logic [ACC_BITS-1:0] q;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        q <= '0;
      end else if ((state == ST_CLEAR) && (clr_idx == G_W'(i / WPW))) begin
        q <= '0;
      end else if (chg_fire && (chg_group_i == G_W'(i / WPW))) begin
        q <= lane_sum[i % WPW];
      end
    end
    assign acc[i] = q;
  end

  // Read word mux sees register contents before any same-cycle update
  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < RWORDS; r++) begin
      if (rd_addr_i == R_W'(r)) begin
        for (int unsigned j = 0; j < RPW; j++) rd_word[j*ACC_BITS +: ACC_BITS] = acc[r*RPW + j];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      sat_flag_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_word;
      if (chg_fire && (|lane_ovf)) sat_flag_o <= 1'b1;
      else if (sat_clr_i)          sat_flag_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator at default parameters.
module tb_synapse_accumulator;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        chg_valid_i;
  logic        chg_ready_o;
  logic [4:0]  chg_group_i;
  logic [31:0] chg_data_i;
  logic        clr_req_i;
  logic        busy_o;
  logic        rd_en_i;
  logic [5:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        sat_flag_o;
  logic        sat_clr_i;

  int checks   = 0;
  int failures = 0;
  int cnt;

  synapse_accumulator dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .chg_valid_i(chg_valid_i),
    .chg_ready_o(chg_ready_o),
    .chg_group_i(chg_group_i),
    .chg_data_i (chg_data_i),
    .clr_req_i  (clr_req_i),
    .busy_o     (busy_o),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .sat_flag_o (sat_flag_o),
    .sat_clr_i  (sat_clr_i)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic charge(input int g, input logic [31:0] d);
    chg_valid_i = 1'b1;
    chg_group_i = 5'(g);
    chg_data_i  = d;
    tick();
    chg_valid_i = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    rd_en_i   = 1'b1;
    rd_addr_i = 6'(a);
    tick();
    rd_en_i = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    chk(tag, rd_data_o, exp);
  endtask

  initial begin
    RSTN = 1'b0; chg_valid_i = 1'b0; chg_group_i = '0; chg_data_i = '0;
    clr_req_i = 1'b0; rd_en_i = 1'b0; rd_addr_i = '0; sat_clr_i = 1'b0;
    repeat (3) tick();
    chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_sat", 32'(sat_flag_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    RSTN = 1'b1;
    tick();
    chk("rst_ready", 32'(chg_ready_o), 32'd1);

    // Single charge, read-back, valid drop and data hold
    charge(3, 32'h7777_7777);
    chk("g3_sat", 32'(sat_flag_o), 32'd0);
    rd(6, 32'h0707_0707, "g3_idx6");
    rd(7, 32'h0707_0707, "g3_idx7");
    tick();
    chk("rdv_low", 32'(rd_valid_o), 32'd0);
    chk("rd_hold", rd_data_o, 32'h0707_0707);
    rd(5, 32'h0, "idx5_zero");

    // Mixed-sign weights on group 2
    charge(2, 32'h0123_89AB);
    rd(4, 32'hF8F9_FAFB, "g2_idx4");
    rd(5, 32'h0001_0203, "g2_idx5");

    // Positive saturation on group 0
    repeat (18) charge(0, 32'h7777_7777);
    rd(0, 32'h7E7E_7E7E, "g0_126");
    chk("g0_no_sat", 32'(sat_flag_o), 32'd0);
    charge(0, 32'h7777_7777);
    rd(0, 32'h7F7F_7F7F, "g0_idx0_sat");
    rd(1, 32'h7F7F_7F7F, "g0_idx1_sat");
    chk("g0_sat_set", 32'(sat_flag_o), 32'd1);
    sat_clr_i = 1'b1; tick(); sat_clr_i = 1'b0;
    chk("sat_clr", 32'(sat_flag_o), 32'd0);
    sat_clr_i = 1'b1;
    charge(0, 32'h7777_7777);
    sat_clr_i = 1'b0;
    chk("sat_set_wins", 32'(sat_flag_o), 32'd1);
    sat_clr_i = 1'b1; tick(); sat_clr_i = 1'b0;
    chk("sat_clr2", 32'(sat_flag_o), 32'd0);

    // Negative bound: -128 reached exactly without overflow, then clamped
    repeat (16) charge(1, 32'h8888_8888);
    rd(2, 32'h8080_8080, "g1_min");
    chk("g1_no_sat", 32'(sat_flag_o), 32'd0);
    charge(1, 32'h8888_8888);
    rd(3, 32'h8080_8080, "g1_clamp");
    chk("g1_sat_set", 32'(sat_flag_o), 32'd1);
    sat_clr_i = 1'b1; tick(); sat_clr_i = 1'b0;

    // Clear request beats a same-cycle charge, sweep lasts 32 cycles
    clr_req_i = 1'b1; chg_valid_i = 1'b1; chg_group_i = 5'd3; chg_data_i = 32'h1111_1111;
    #1;
    chk("clr_ready_low", 32'(chg_ready_o), 32'd0);
    tick();
    clr_req_i = 1'b0; chg_valid_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 32'd1);
    chk("clr_ready_busy", 32'(chg_ready_o), 32'd0);
    cnt = 0;
    while (busy_o && cnt < 100) begin
      clr_req_i = (cnt == 5);
      cnt++;
      tick();
    end
    clr_req_i = 1'b0;
    chk("busy_cycles", 32'(cnt), 32'd32);
    for (int r = 0; r < 64; r++) rd(r, 32'h0, $sformatf("post_clear_%0d", r));

    // Read sees pre-charge value when issued in the charge cycle
    chg_valid_i = 1'b1; chg_group_i = 5'd0; chg_data_i = 32'h1111_1111;
    rd_en_i = 1'b1; rd_addr_i = 6'd0;
    tick();
    chg_valid_i = 1'b0; rd_en_i = 1'b0;
    chk("pre_charge", rd_data_o, 32'h0);
    rd(0, 32'h0101_0101, "post_charge");

    // Reset in the middle of a clear sweep
    repeat (19) charge(20, 32'h7777_7777);
    rd(40, 32'h7F7F_7F7F, "g20_sat");
    chk("g20_sat_flag", 32'(sat_flag_o), 32'd1);
    clr_req_i = 1'b1; tick(); clr_req_i = 1'b0;
    repeat (10) tick();
    chk("busy_before_rst", 32'(busy_o), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_sat", 32'(sat_flag_o), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("arst_rd_data", rd_data_o, 32'h0);
    tick();
    RSTN = 1'b1;
    tick();
    chk("rel_busy", 32'(busy_o), 32'd0);
    chk("rel_ready", 32'(chg_ready_o), 32'd1);
    rd(40, 32'h0, "rel_idx40");
    rd(41, 32'h0, "rel_idx41");
    charge(31, 32'h0000_0001);
    rd(62, 32'h0000_0001, "g31_idx62");
    rd(63, 32'h0, "g31_idx63");
    chk("no_resume", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
SYNAPSE_ACCUMULATOR -- requirements
Module: synapse_accumulator

Interface
REQ-001 SHALL have parameter N, default 256: number of neuron accumulators (power of 2, at least 16).
REQ-002 SHALL have parameter W_BITS, default 4: signed two's-complement synaptic weight width.
REQ-003 SHALL have parameter ACC_BITS, default 8: signed accumulator width, greater than W_BITS.
REQ-004 SHALL have parameter DATA_W, default 32: bus width; WPW = DATA_W/W_BITS weights per charge word; RPW = DATA_W/ACC_BITS accumulators per read word.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: CLK  in  1  clock; RSTN  in  1  asynchronous active-low reset.
REQ-006 chg_valid_i  in  1  charge word valid.
REQ-007 chg_ready_o  out  1  charge word accepted when high with valid.
REQ-008 chg_group_i  in  clog2(N/WPW)  target group; lanes group*WPW+k, k=0..WPW-1.
REQ-009 chg_data_i  in  DATA_W  packed weights; lane k = bits [k*W_BITS +: W_BITS].
REQ-010 clr_req_i  in  1  single-cycle request to zero all accumulators.
REQ-011 busy_o  out  1  clear sweep in progress.
REQ-012 rd_en_i  in  1  read request; rd_addr_i  in  clog2(N/RPW)  read word index.
REQ-013 rd_data_o  out  DATA_W  accumulators rd_addr*RPW+j in bits [j*ACC_BITS +: ACC_BITS]; rd_valid_o  out  1.
REQ-014 sat_flag_o  out  1  sticky saturation indicator; sat_clr_i  in  1  clears it.

Function
REQ-015 FSM SHALL have states IDLE and CLEAR; reset state IDLE.
REQ-016 chg_ready_o SHALL equal (state==IDLE) and not clr_req_i, combinationally.
REQ-017 On handshake, each lane SHALL update the next cycle to sat(acc + sign-extended weight), clamped to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
REQ-018 A lane whose unclamped sum falls outside range SHALL set sat_flag_o the next cycle; flag holds until sat_clr_i or reset; set wins over simultaneous sat_clr_i.
REQ-019 clr_req_i in IDLE SHALL enter CLEAR; each CLEAR cycle zeroes WPW accumulators of one group, index 0..N/WPW-1 ascending; after the last group, return to IDLE; busy_o = (state==CLEAR).
REQ-020 clr_req_i while in CLEAR SHALL be ignored.
REQ-021 Reads SHALL be accepted in any state; rd_data_o/rd_valid_o registered, 1-cycle latency; data reflects contents before any same-cycle update.
REQ-022 rd_valid_o SHALL be low in cycles after rd_en_i low; rd_data_o holds its last value.
REQ-023 Groups and read indices SHALL not wrap or alias; all widths exact from parameters.

Reset
REQ-024 RSTN low SHALL asynchronously zero all accumulators, set state IDLE, rd_data_o=0, rd_valid_o=0, sat_flag_o=0; busy_o=0; chg_ready_o=1 once released.
REQ-025 Reset during CLEAR SHALL abort the sweep with the state above; no partial sweep resumes.

Structure
REQ-026 Shared package synapse_acc_pkg SHALL hold the FSM state enum and the saturation-bound constant functions of ACC_BITS.
REQ-027 One sub-module sat_add_lane (sign-extend, add, clamp, overflow flag) SHALL be instantiated WPW times.

Verification (defaults N=256, W=4, ACC=8, DATA_W=32)
REQ-028 Charge group 3 with 0x7777_7777 once -> read index 6 and 7 next-cycle data 0x0707_0707, sat_flag 0.
REQ-029 Charge group 0 with 0x7777_7777 19 times -> lanes 0..7 = 127 (0x7F), sat_flag 1; sat_clr_i pulse -> 0.
REQ-030 Charge group 1 with 0x8888_8888 17 times -> lanes 8..15 = -128 (0x80), sat_flag 1.
REQ-031 clr_req_i with chg_valid_i same cycle -> chg_ready_o 0, busy_o high exactly 32 cycles, all reads 0 afterwards.
REQ-032 Read index 0 same cycle as charge to group 0 -> rd_data_o shows pre-charge value; next read shows updated value.
REQ-033 RSTN low at cycle 10 of CLEAR -> busy_o 0, all accumulators 0, new charge accepted after release.
